// File: rtl/rx_mac_if.sv
// XGMII receive and AXI-Stream output bundles for rx_mac.
// rx_mac_xgmii_if : 32-bit XGMII receive word plus qualifier (master = PHY side).
// rx_mac_axis_if  : AXI-Stream frame output without backpressure (master = rx_mac).

interface rx_mac_xgmii_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
);
  logic [DATA_W-1:0] rxd;
  logic [CTRL_W-1:0] rxc;
  logic              valid;

  modport master (output rxd, rxc, valid);
  modport slave  (input  rxd, rxc, valid);
endinterface

interface rx_mac_axis_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
);
  logic [DATA_W-1:0] tdata;
  logic [CTRL_W-1:0] tkeep;
  logic              tvalid;
  logic              tlast;
  logic              tuser;

  modport master (output tdata, tkeep, tvalid, tlast, tuser);
  modport slave  (input  tdata, tkeep, tvalid, tlast, tuser);
endinterface

// File: rtl/rx_mac.sv
// rx_mac: XGMII (32-bit, 4 lanes) receive MAC to AXI-Stream.
// Detects start + SFD, streams payload through a two-word delay buffer so the
// trailing 4-byte FCS is never forwarded, and flags bad frames on tuser.
// Optional feature: define RX_MAC_CRC_CHECK_EN to build the CRC-32 checker;
// without it tuser reports aborted frames only.
// The start/SFD/terminate constants assume the default 32-bit, 4-lane word.

module rx_mac #(
  parameter int XGMII_DATA_WIDTH = 32,
  parameter int XGMII_CTRL_WIDTH = 4
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  rx_mac_xgmii_if.slave xgmii,
  rx_mac_axis_if.master m_axis
);

  localparam int DW = XGMII_DATA_WIDTH;
  localparam int CW = XGMII_CTRL_WIDTH;

  localparam logic [DW-1:0] START_WORD = DW'(32'h555555FB);
  localparam logic [CW-1:0] START_CTRL = CW'(1);
  localparam logic [DW-1:0] SFD_WORD   = DW'(32'hD5555555);
  localparam logic [7:0]    TERM_CHAR  = 8'hFD;

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    DATA,
    DRAIN
  } state_t;

  state_t        state_q;
  logic [DW-1:0] buf_q [2];     // [0] = older, [1] = newer word once full
  logic [1:0]    cnt_q;         // words held in buf_q, saturates at 2
  logic [CW-1:0] drain_keep_q;  // byte enables of the final beat in DRAIN
  logic          drain_bad_q;   // CRC verdict carried into DRAIN

  logic [DW-1:0] tdata_q;
  logic [CW-1:0] tkeep_q;
  logic          tvalid_q;
  logic          tlast_q;
  logic          tuser_q;

  logic          in_valid;
  logic          is_start;
  logic          is_sfd;
  logic          any_ctrl;
  logic          term_ok;
  logic [CW-1:0] term_keep;     // lanes below the first control lane
  logic          crc_bad;
  logic [DW-1:0] oldest;

  assign in_valid = xgmii.valid;
  assign is_start = (xgmii.rxc == START_CTRL) && (xgmii.rxd == START_WORD);
  assign is_sfd   = (xgmii.rxc == '0) && (xgmii.rxd == SFD_WORD);
  assign any_ctrl = |xgmii.rxc;
  // With a single word buffered it sits in the newer slot.
  assign oldest   = (cnt_q == 2'd2) ? buf_q[0] : buf_q[1];

  // Find the lowest control lane: it is a terminate only if it carries 0xFD.
  always_comb begin
    logic seen;
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    seen      = 1'b0;
    term_ok   = 1'b0;
    term_keep = '0;
    for (int l = 0; l < CW; l++) begin
      if (!seen) begin
        if (xgmii.rxc[l]) begin
          seen    = 1'b1;
          term_ok = (xgmii.rxd[8*l +: 8] == TERM_CHAR);
        end else begin
          term_keep[l] = 1'b1;
        end
      end
    end
  end

`ifdef RX_MAC_CRC_CHECK_EN
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;

  logic [31:0] crc_q;
  logic [31:0] crc_term;
  logic        crc_clear;
  logic        crc_upd;

  // Reflected CRC-32 over the enabled byte lanes, lane 0 first.
  function automatic logic [31:0] crc_bytes(input logic [31:0]   crc_in,
                                            input logic [DW-1:0] data,
                                            input logic [CW-1:0] lane_en);
    logic [31:0] c;
    c = crc_in;
    for (int l = 0; l < CW; l++) begin
      if (lane_en[l]) begin
        c = c ^ {24'h0, data[8*l +: 8]};
        for (int b = 0; b < 8; b++) begin
          c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
      end
    end
    return c;
  endfunction

  assign crc_clear = in_valid && (state_q == PREAMBLE) && is_sfd;
  assign crc_upd   = in_valid && (state_q == DATA) && !any_ctrl;
  // The terminate word contributes only the bytes below the terminate lane.
  assign crc_term  = crc_bytes(crc_q, xgmii.rxd, term_keep);
  assign crc_bad   = (crc_term != CRC_RESIDUE);

  // Running CRC: seeded at SFD, advanced on every full data/FCS word.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      crc_q <= CRC_INIT;
    end else if (crc_clear) begin
      crc_q <= CRC_INIT;
    end else if (crc_upd) begin
      crc_q <= crc_bytes(crc_q, xgmii.rxd, '1);
    end
  end
`else
  assign crc_bad = 1'b0;
`endif

  // Frame FSM with buffer management and registered AXI-Stream outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= IDLE;
      // NOTE: the two-word buffer is a plain register pair, so it is cleared on reset like any other flop.
      buf_q[0]     <= '0;
      buf_q[1]     <= '0;
      cnt_q        <= '0;
      drain_keep_q <= '0;
      drain_bad_q  <= 1'b0;
      tdata_q      <= '0;
      tkeep_q      <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      tuser_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tuser_q  <= 1'b0;

      case (state_q)
        IDLE: begin
          if (in_valid && is_start) begin
            state_q <= PREAMBLE;
          end
        end

        PREAMBLE: begin
          if (in_valid) begin
            cnt_q   <= '0;
            state_q <= is_sfd ? DATA : IDLE;
          end
        end

        DATA: begin
          if (in_valid) begin
            if (!any_ctrl) begin
              // Plain data/FCS word: release the oldest once two are held.
              if (cnt_q == 2'd2) begin
                tdata_q  <= buf_q[0];
                tkeep_q  <= '1;
                tvalid_q <= 1'b1;
              end else begin
                cnt_q <= cnt_q + 2'd1;
              end
              buf_q[0] <= buf_q[1];
              buf_q[1] <= xgmii.rxd;
            end else if (term_ok) begin
              cnt_q <= '0;
              if (cnt_q != 2'd2) begin
                // Too short to hold payload beyond the FCS: drop silently.
                state_q <= IDLE;
              end else if (xgmii.rxc[0]) begin
                // Terminate in lane 0: the newer word is pure FCS.
                tdata_q  <= buf_q[0];
                tkeep_q  <= '1;
                tvalid_q <= 1'b1;
                tlast_q  <= 1'b1;
                tuser_q  <= crc_bad;
                state_q  <= IDLE;
              end else begin
                // Terminate in a later lane: the newer word still has payload bytes.
                tdata_q      <= buf_q[0];
                tkeep_q      <= '1;
                tvalid_q     <= 1'b1;
                buf_q[0]     <= buf_q[1];
                drain_keep_q <= term_keep;
                drain_bad_q  <= crc_bad;
                state_q      <= DRAIN;
              end
            end else begin
              // Error or misplaced control character: close the frame as bad.
              cnt_q <= '0;
              if (cnt_q != 2'd0) begin
                tdata_q  <= oldest;
                tkeep_q  <= '1;
                tvalid_q <= 1'b1;
                tlast_q  <= 1'b1;
                tuser_q  <= 1'b1;
              end
              state_q <= IDLE;
            end
          end
        end

        DRAIN: begin
          // Final partial beat; a start word may already arrive in this cycle.
          tdata_q  <= buf_q[0];
          tkeep_q  <= drain_keep_q;
          tvalid_q <= 1'b1;
          tlast_q  <= 1'b1;
          tuser_q  <= drain_bad_q;
          state_q  <= (in_valid && is_start) ? PREAMBLE : IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_axis.tdata  = tdata_q;
  assign m_axis.tkeep  = tkeep_q;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast  = tlast_q;
  assign m_axis.tuser  = tuser_q;

endmodule

// File: tb/tb_rx_mac.sv
// Directed testbench for rx_mac: builds XGMII frames with a correct FCS,
// derives the expected AXI-Stream beats from the payload and compares them.

module tb_rx_mac;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  c;
  } xword_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        user;
  } beat_t;

  localparam logic [31:0] IDLE_D  = 32'h0707_0707;
  localparam logic [31:0] START_D = 32'h5555_55FB;
  localparam logic [31:0] SFD_D   = 32'hD555_5555;

`ifdef RX_MAC_CRC_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;

  int checks    = 0;
  int errors    = 0;
  int flag_errs = 0;
  int drain_cyc = 0;

  xword_t     stim_q[$];
  beat_t      exp_q[$];
  beat_t      got_q[$];
  logic [7:0] pl_q[$];

  rx_mac_xgmii_if #(.DATA_W(32), .CTRL_W(4)) x_if ();
  rx_mac_axis_if  #(.DATA_W(32), .CTRL_W(4)) a_if ();

  rx_mac #(
    .XGMII_DATA_WIDTH(32),
    .XGMII_CTRL_WIDTH(4)
  ) dut (
    .i_clk    (clk),
    .i_reset_n(rst_n),
    .xgmii    (x_if),
    .m_axis   (a_if)
  );

  always #5 clk = ~clk;

  // Output monitor, sampled on the falling edge away from output updates.
  always @(negedge clk) begin
    if (a_if.tvalid) begin
      got_q.push_back({a_if.tdata, a_if.tkeep, a_if.tlast, a_if.tuser});
    end else if (a_if.tlast || a_if.tuser) begin
      flag_errs++;
    end
    if (dut.state_q.name() == "DRAIN") drain_cyc++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic make_payload(input int n, input logic [7:0] seed);
    pl_q.delete();
    for (int i = 0; i < n; i++) pl_q.push_back(8'(seed + i * 13));
  endtask

  // Reference Ethernet FCS: bitwise reflected CRC-32, complemented.
  function automatic logic [31:0] fcs_of();
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFF_FFFF;
    foreach (pl_q[i]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ pl_q[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB8_8320;
      end
    end
    return ~c;
  endfunction

  // Append start, SFD, payload+FCS, terminate (and optional idle gap); queue expected beats.
  task automatic add_frame(input bit corrupt, input bit gap, input bit user_exp);
    logic [7:0]  bytes[$];
    logic [31:0] fcs;
    logic [31:0] d;
    logic [3:0]  c;
    beat_t       bt;
    int          n, full, k, nb;
    fcs   = fcs_of();
    bytes = pl_q;
    for (int i = 0; i < 4; i++) bytes.push_back(fcs[8*i +: 8]);
    if (corrupt) bytes[5] = bytes[5] ^ 8'h04;
    stim_q.push_back({START_D, 4'b0001});
    stim_q.push_back({SFD_D, 4'b0000});
    full = bytes.size() / 4;
    k    = bytes.size() % 4;
    for (int w = 0; w < full; w++) begin
      stim_q.push_back({bytes[4*w+3], bytes[4*w+2], bytes[4*w+1], bytes[4*w], 4'b0000});
    end
    d = IDLE_D;
    c = 4'b1111;
    for (int l = 0; l < k; l++) begin
      d[8*l +: 8] = bytes[4*full+l];
      c[l]        = 1'b0;
    end
    d[8*k +: 8] = 8'hFD;
    stim_q.push_back({d, c});
    if (gap) stim_q.push_back({IDLE_D, 4'b1111});
    n  = pl_q.size();
    nb = (n < 4) ? 0 : (n + 3) / 4;
    for (int b = 0; b < nb; b++) begin
      bt.data = {bytes[4*b+3], bytes[4*b+2], bytes[4*b+1], bytes[4*b]};
      bt.last = (b == nb - 1);
      bt.keep = (bt.last && (n % 4 != 0)) ? 4'((1 << (n % 4)) - 1) : 4'hF;
      bt.user = bt.last ? user_exp : 1'b0;
      exp_q.push_back(bt);
    end
  endtask

  task automatic drive(input logic [31:0] d, input logic [3:0] c, input logic v);
    @(negedge clk);
    x_if.rxd   = d;
    x_if.rxc   = c;
    x_if.valid = v;
  endtask

  // Play the stimulus queue; gap3 drops valid on every third cycle.
  task automatic run_stim(input bit gap3, input int tail);
    int cyc;
    cyc = 0;
    foreach (stim_q[i]) begin
      if (gap3 && (cyc % 3 == 2)) begin
        drive(START_D, 4'b0001, 1'b0);
        cyc++;
      end
      drive(stim_q[i].d, stim_q[i].c, 1'b1);
      cyc++;
    end
    for (int i = 0; i < tail; i++) drive(IDLE_D, 4'b1111, 1'b1);
    stim_q.delete();
  endtask

  task automatic compare(input string tag, input int n_hand, input int base);
    int          n;
    beat_t       g, e;
    logic [31:0] m;
    n = got_q.size() - base;
    check({tag, "_nbeats"}, n, n_hand);
    for (int i = 0; i < exp_q.size() && i < n; i++) begin
      g = got_q[base+i];
      e = exp_q[i];
      for (int l = 0; l < 4; l++) m[8*l +: 8] = {8{e.keep[l]}};
      check($sformatf("%s_b%0d_data", tag, i), g.data & m, e.data & m);
      check($sformatf("%s_b%0d_keep", tag, i), g.keep, e.keep);
      check($sformatf("%s_b%0d_last", tag, i), g.last, e.last);
      check($sformatf("%s_b%0d_user", tag, i), g.user, e.user);
    end
    exp_q.delete();
  endtask

  initial begin
    int base;
    int d0;
    int lasts;

    x_if.rxd   = IDLE_D;
    x_if.rxc   = 4'b1111;
    x_if.valid = 1'b0;
    rst_n      = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tvalid", a_if.tvalid, 1'b0);
    check("rst_tlast",  a_if.tlast,  1'b0);
    check("rst_tuser",  a_if.tuser,  1'b0);
    check("rst_tdata",  a_if.tdata,  32'h0);
    check("rst_tkeep",  a_if.tkeep,  4'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 64-byte frame, terminate in lane 0
    base = got_q.size();
    make_payload(60, 8'h10);
    add_frame(1'b0, 1'b1, 1'b0);
    run_stim(1'b0, 6);
    compare("f64", 15, base);

    // 65-byte frame, terminate in lane 1, one DRAIN cycle
    base = got_q.size();
    d0   = drain_cyc;
    make_payload(61, 8'h20);
    add_frame(1'b0, 1'b1, 1'b0);
    run_stim(1'b0, 6);
    compare("f65", 16, base);
    check("f65_drain", drain_cyc - d0, 1);

    // terminate in lanes 2 and 3
    base = got_q.size();
    make_payload(62, 8'h31);
    add_frame(1'b0, 1'b1, 1'b0);
    run_stim(1'b0, 6);
    compare("f66", 16, base);
    base = got_q.size();
    make_payload(63, 8'h42);
    add_frame(1'b0, 1'b1, 1'b0);
    run_stim(1'b0, 6);
    compare("f67", 16, base);

    // same 65-byte frame with one data bit flipped
    base = got_q.size();
    make_payload(61, 8'h20);
    add_frame(1'b1, 1'b1, CRC_EN);
    run_stim(1'b0, 6);
    compare("f65_bad", 16, base);

    // short frames: 7 and 4 bytes dropped, 8 bytes gives one beat
    base = got_q.size();
    make_payload(3, 8'h55);
    add_frame(1'b0, 1'b1, 1'b0);
    run_stim(1'b0, 6);
    compare("short7", 0, base);
    base = got_q.size();
    make_payload(0, 8'h55);
    add_frame(1'b0, 1'b1, 1'b0);
    run_stim(1'b0, 6);
    compare("short4", 0, base);
    base = got_q.size();
    make_payload(4, 8'h66);
    add_frame(1'b0, 1'b1, 1'b0);
    run_stim(1'b0, 6);
    compare("min8", 1, base);

    // error character at data word 5: D0..D3 out, D3 flagged
    base = got_q.size();
    make_payload(20, 8'h70);
    stim_q.push_back({START_D, 4'b0001});
    stim_q.push_back({SFD_D, 4'b0000});
    for (int w = 0; w < 5; w++) begin
      stim_q.push_back({pl_q[4*w+3], pl_q[4*w+2], pl_q[4*w+1], pl_q[4*w], 4'b0000});
      if (w < 4) exp_q.push_back({pl_q[4*w+3], pl_q[4*w+2], pl_q[4*w+1], pl_q[4*w],
                                  4'hF, w == 3, w == 3});
    end
    stim_q.push_back({32'h0302_01FE, 4'b0001});
    stim_q.push_back({IDLE_D, 4'b1111});
    run_stim(1'b0, 6);
    compare("abort", 4, base);
    check("abort_idle", dut.state_q.name() == "IDLE", 1'b1);
    base = got_q.size();
    make_payload(60, 8'h81);
    add_frame(1'b0, 1'b1, 1'b0);
    run_stim(1'b0, 6);
    compare("post_abort", 15, base);

    // back-to-back: next start word lands in the DRAIN cycle
    base = got_q.size();
    make_payload(61, 8'h92);
    add_frame(1'b0, 1'b0, 1'b0);
    make_payload(60, 8'hA3);
    add_frame(1'b0, 1'b1, 1'b0);
    run_stim(1'b0, 6);
    compare("b2b", 31, base);

    // 128-byte frame with valid low every third cycle
    base = got_q.size();
    make_payload(124, 8'hB4);
    add_frame(1'b0, 1'b1, 1'b0);
    run_stim(1'b1, 6);
    compare("gap", 31, base);

    // reset at data word 10, then a clean frame
    base = got_q.size();
    make_payload(60, 8'hC5);
    add_frame(1'b0, 1'b1, 1'b0);
    while (stim_q.size() > 12) void'(stim_q.pop_back());
    exp_q.delete();
    run_stim(1'b0, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_tvalid", a_if.tvalid, 1'b0);
    check("midrst_tdata",  a_if.tdata,  32'h0);
    check("midrst_tkeep",  a_if.tkeep,  4'h0);
    x_if.rxd   = IDLE_D;
    x_if.rxc   = 4'b1111;
    x_if.valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    lasts = 0;
    for (int i = base; i < got_q.size(); i++) if (got_q[i].last) lasts++;
    check("midrst_nolast", lasts, 0);
    base = got_q.size();
    make_payload(60, 8'hD6);
    add_frame(1'b0, 1'b1, 1'b0);
    run_stim(1'b0, 6);
    compare("post_rst", 15, base);

    check("idle_flags", flag_errs, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
